// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer for the MIPS CPU clock enable, plus a
// RAM-address scanner for the 7-segment display while the CPU is frozen.
// Everything runs on clk; cpu_ce is a one-cycle enable pulse, never a clock.
module cpu_run_ctrl #(
  parameter int unsigned DIV0        = 10000,
  parameter int unsigned DIV1        = 100000,
  parameter int unsigned DIV2        = 1000000,
  parameter int unsigned DIV3        = 10000000,
  parameter int unsigned SCAN_STEP   = 4,
  parameter int unsigned SCAN_LAST   = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  hz_sel,
  input  logic        run_mode,
  input  logic        go,
  input  logic        scan_en,
  input  logic        cpu_halt,
  output logic        cpu_ce,
  output logic [31:0] scan_addr,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRun  = 3'd1,
    StStep = 3'd2,
    StHalt = 3'd3,
    StScan = 3'd4
  } state_e;

  state_e state_q, state_d, saved_q, saved_d;

  logic [SYNC_STAGES-1:0] go_sync_q, scan_sync_q;
  logic        go_prev_q, go_edge_q, halt_prev_q;
  logic        halt_pend_q, halt_pend_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic [31:0] cnt_q, cnt_d, div_q, div_d, div_sel;
  logic [31:0] scan_addr_q, scan_addr_d, cycle_cnt_q;
  logic        go_s, scan_s, halt_edge, tick, in_timed, timed_next;

  assign go_s      = go_sync_q[SYNC_STAGES-1];
  assign scan_s    = scan_sync_q[SYNC_STAGES-1];
  assign halt_edge = cpu_halt & ~halt_prev_q;
  assign tick      = (cnt_q == div_q - 32'd1);

  // Input synchronisers; go edge is registered so the FSM sees a clean pulse
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      go_sync_q   <= '0;
      scan_sync_q <= '0;
      go_prev_q   <= 1'b0;
      go_edge_q   <= 1'b0;
      halt_prev_q <= 1'b0;
    end else begin
      go_sync_q   <= {go_sync_q[SYNC_STAGES-2:0], go};
      scan_sync_q <= {scan_sync_q[SYNC_STAGES-2:0], scan_en};
      go_prev_q   <= go_s;
      go_edge_q   <= go_s & ~go_prev_q;
      halt_prev_q <= cpu_halt;
    end
  end

  // Rate decode from the board switches
  always_comb begin
    div_sel = 32'(DIV0);
    unique case (hz_sel)
      2'b00:   div_sel = 32'(DIV0);
      2'b01:   div_sel = 32'(DIV1);
      2'b10:   div_sel = 32'(DIV2);
      default: div_sel = 32'(DIV3);
    endcase
  end

  // Next-state, enable pulse, scan address and pending-halt bookkeeping
  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    halt_pend_d = halt_pend_q;
    cpu_ce_d    = 1'b0;
    scan_addr_d = scan_addr_q;
    // Scan freeze wins over everything except idle and scan itself
    if (state_q != StIdle && state_q != StScan && scan_s) begin
      state_d = StScan;
      saved_d = state_q;
      if (halt_edge) halt_pend_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          if (go_edge_q) state_d = run_mode ? StRun : StStep;
        end
        StRun: begin
          if (halt_edge)      state_d = StHalt;
          else if (!run_mode) state_d = StStep;
          else                cpu_ce_d = tick;
        end
        StStep: begin
          if (halt_edge) begin
            state_d = StHalt;
          end else begin
            cpu_ce_d = go_edge_q;
            if (run_mode) state_d = StRun;
          end
        end
        StScan: begin
          if (!scan_s) begin
            scan_addr_d = '0;
            halt_pend_d = 1'b0;
            state_d     = halt_pend_q ? StHalt : saved_q;
          end else begin
            if (tick) begin
              scan_addr_d = (scan_addr_q == 32'(SCAN_LAST)) ? '0
                                                              : scan_addr_q + 32'(SCAN_STEP);
            end
            if (halt_edge) halt_pend_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign in_timed   = (state_q == StRun) || (state_q == StScan);
  assign timed_next = (state_d == StRun) || (state_d == StScan);

  // Prescaler: rate re-latched only at wrap or on entry, so periods never glitch
  always_comb begin
    cnt_d = '0;
    div_d = div_q;
    if (timed_next && state_d != state_q) begin
      div_d = div_sel;
    end else if (in_timed && state_d == state_q) begin
      if (tick) div_d = div_sel;
      else      cnt_d = cnt_q + 32'd1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= StIdle;
      saved_q     <= StIdle;
      halt_pend_q <= 1'b0;
      cpu_ce_q    <= 1'b0;
      cnt_q       <= '0;
      div_q       <= 32'(DIV0);
      scan_addr_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      halt_pend_q <= halt_pend_d;
      cpu_ce_q    <= cpu_ce_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      scan_addr_q <= scan_addr_d;
      cycle_cnt_q <= cycle_cnt_q + {31'd0, cpu_ce_d};
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign scan_addr = scan_addr_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: constant-expectation vector table, directed corner
// sequences and random stimulus, all shadowed cycle by cycle by a reference model.
module tb_cpu_run_ctrl;
  localparam int S  = 2;
  localparam int D0 = 4, D1 = 8, D2 = 2, D3 = 3;
  localparam int SSTEP = 4, SLAST = 64;

  logic        clk = 1'b0, clr = 1'b0;
  logic [1:0]  hz_sel = 2'd0;
  logic        run_mode = 1'b0, go = 1'b0, scan_en = 1'b0, cpu_halt = 1'b0;
  logic        cpu_ce;
  logic [31:0] scan_addr, cycle_cnt;
  logic [2:0]  state;

  int n_chk = 0, n_fail = 0, pulse_acc = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3),
    .SCAN_STEP(SSTEP), .SCAN_LAST(SLAST), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .clr(clr), .hz_sel(hz_sel), .run_mode(run_mode), .go(go),
    .scan_en(scan_en), .cpu_halt(cpu_halt), .cpu_ce(cpu_ce), .scan_addr(scan_addr),
    .state(state), .cycle_cnt(cycle_cnt)
  );

  // Reference model: states 0..4 as plain ints, delayed input samples in arrays,
  // prescaler as "cycles left until tick".
  int          m_state, m_saved, m_left;
  bit          m_ce, m_pend, m_hprev;
  int unsigned m_addr, m_cnt;
  bit          gq[S+2];
  bit          sq[S+2];

  function automatic int div_of(logic [1:0] h);
    case (h)
      2'd0: return D0;
      2'd1: return D1;
      2'd2: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_saved = 0; m_left = 0; m_ce = 0; m_pend = 0; m_hprev = 0;
    m_addr = 0; m_cnt = 0;
    for (int i = 0; i < S + 2; i++) begin gq[i] = 0; sq[i] = 0; end
  endtask

  task automatic model_edge();
    bit ge, ss, he, tk;
    int ns;
    ge = gq[S] && !gq[S+1];
    ss = sq[S-1];
    he = cpu_halt && !m_hprev;
    tk = (m_state == 1 || m_state == 4) && m_left == 1;
    ns = m_state;
    m_ce = 0;
    if (m_state != 0 && m_state != 4 && ss) begin
      ns = 4; m_saved = m_state;
      if (he) m_pend = 1;
    end else begin
      case (m_state)
        0, 3: if (ge) ns = run_mode ? 1 : 2;
        1: begin
          if (he) ns = 3;
          else if (!run_mode) ns = 2;
          else m_ce = tk;
        end
        2: begin
          if (he) ns = 3;
          else begin m_ce = ge; if (run_mode) ns = 1; end
        end
        default: begin
          if (!ss) begin
            m_addr = 0; ns = m_pend ? 3 : m_saved; m_pend = 0;
          end else begin
            if (tk) m_addr = (m_addr == SLAST) ? 0 : m_addr + SSTEP;
            if (he) m_pend = 1;
          end
        end
      endcase
    end
    if ((ns == 1 || ns == 4) && ns != m_state) m_left = div_of(hz_sel);
    else if ((ns == 1 || ns == 4) && ns == m_state) m_left = tk ? div_of(hz_sel) : m_left - 1;
    if (m_ce) m_cnt++;
    m_state = ns;
    m_hprev = cpu_halt;
    for (int i = S + 1; i > 0; i--) begin gq[i] = gq[i-1]; sq[i] = sq[i-1]; end
    gq[0] = go;
    sq[0] = scan_en;
  endtask

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: advance model alongside DUT, compare all outputs after the edge
  task automatic cyc();
    @(posedge clk);
    if (clr) model_edge();
    #1;
    chk("state", state, m_state);
    chk("cpu_ce", cpu_ce, m_ce);
    chk("scan_addr", scan_addr, m_addr);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    if (cpu_ce) pulse_acc++;
  endtask

  task automatic wait_state(int want, int bound, string name);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (state == 3'(want)) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_pulse(int bound, output int n);
    n = 0;
    do begin cyc(); n++; end while (!cpu_ce && n < bound);
  endtask

  task automatic press_go();
    go = 1'b1; cyc(); go = 1'b0;
  endtask

  typedef struct {
    int         ncyc;
    bit         g, r, h, s;
    logic [1:0] hz;
    int         st;
    int         cnt;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int n;
    // Hand-derived from reset release: go sampled at row 1, RUN three edges later,
    // pulses every 4 cycles, then step, halt, and resume with cpu_halt still high.
    tbl[0]  = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0};
    tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0};
    tbl[2]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0};
    tbl[3]  = '{2,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1, 0};
    tbl[4]  = '{4,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1, 1};
    tbl[5]  = '{36, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1, 10};
    tbl[6]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2, 10};
    tbl[7]  = '{1,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3, 10};
    tbl[8]  = '{1,  1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 3, 10};
    tbl[9]  = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1, 10};
    tbl[10] = '{3,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1, 10};
    tbl[11] = '{1,  1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1, 11};

    model_reset();
    for (int i = 0; i < 3; i++) cyc();
    clr = 1'b1;

    for (int i = 0; i < 12; i++) begin
      go = tbl[i].g; run_mode = tbl[i].r; cpu_halt = tbl[i].h;
      scan_en = tbl[i].s; hz_sel = tbl[i].hz;
      for (int c = 0; c < tbl[i].ncyc; c++) cyc();
      chk($sformatf("vec%0d_state", i), state, tbl[i].st);
      chk($sformatf("vec%0d_cnt", i), cycle_cnt, tbl[i].cnt);
    end

    // Single step: three presses, the last held 100 cycles -> three pulses
    cpu_halt = 1'b0; run_mode = 1'b0;
    cyc();
    pulse_acc = 0;
    press_go();
    for (int i = 0; i < 10; i++) cyc();
    press_go();
    for (int i = 0; i < 10; i++) cyc();
    go = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    go = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("step_pulses", pulse_acc, 3);
    chk("step_state", state, 2);

    // Halt rising in the tick cycle swallows the pulse
    run_mode = 1'b1;
    wait_state(1, 5, "enter_run");
    n = 0;
    while (!(m_state == 1 && m_left == 1) && n < 20) begin cyc(); n++; end
    chk("found_tick", (n < 20), 1);
    cpu_halt = 1'b1;
    cyc();
    chk("halt_no_ce", cpu_ce, 0);
    chk("halt_state", state, 3);
    press_go();
    wait_state(1, 10, "resume_run");
    pulse_acc = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("no_rehalt_state", state, 1);
    chk("no_rehalt_pulses", pulse_acc, 3);

    // Scan with period 2: address walks 0..64 and wraps; halt during scan -> HALT
    cpu_halt = 1'b0; hz_sel = 2'd2; scan_en = 1'b1;
    wait_state(4, 10, "enter_scan");
    begin
      int          changes = 0;
      int unsigned prev = 0, want;
      bit          seq_ok = 1;
      pulse_acc = 0;
      for (int i = 0; i < 50; i++) begin
        cpu_halt = (i == 20);
        cyc();
        if (scan_addr != prev) begin
          want = (prev == SLAST) ? 0 : prev + SSTEP;
          if (scan_addr != want) seq_ok = 0;
          prev = scan_addr;
          changes++;
        end
      end
      chk("scan_seq_ok", seq_ok, 1);
      chk("scan_changes", changes, 25);
      chk("scan_no_ce", pulse_acc, 0);
    end
    cpu_halt = 1'b0; scan_en = 1'b0;
    n = 0;
    while (state == 3'd4 && n < 10) begin cyc(); n++; end
    chk("scan_exit_state", state, 3);
    chk("scan_exit_addr", scan_addr, 0);

    // Rate change mid-period: current period stays 4, following periods 8
    hz_sel = 2'd0; run_mode = 1'b1;
    press_go();
    wait_state(1, 10, "rate_run");
    wait_pulse(20, n);
    chk("rate_first_pulse", cpu_ce, 1);
    cyc(); cyc();
    hz_sel = 2'd1;
    wait_pulse(20, n);
    chk("rate_gap0", n + 2, 4);
    wait_pulse(20, n);
    chk("rate_gap1", n, 8);
    wait_pulse(20, n);
    chk("rate_gap2", n, 8);

    // Asynchronous clear mid-RUN with cycle_cnt=5
    clr = 1'b0; model_reset(); cyc(); clr = 1'b1;
    hz_sel = 2'd0;
    press_go();
    wait_state(1, 10, "clr_run");
    n = 0;
    while (m_cnt != 5 && n < 60) begin cyc(); n++; end
    chk("clr_cnt5", cycle_cnt, 5);
    #2 clr = 1'b0;
    #1;
    chk("clr_state", state, 0);
    chk("clr_ce", cpu_ce, 0);
    chk("clr_cnt", cycle_cnt, 0);
    model_reset();
    cyc();
    clr = 1'b1;
    scan_en = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_ignores_scan", state, 0);
    scan_en = 1'b0;
    cyc();

    // Random phase against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 8) == 0)   go = ~go;
      if ($urandom_range(0, 59) == 0)  run_mode = ~run_mode;
      if ($urandom_range(0, 149) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 24) == 0)  cpu_halt = ~cpu_halt;
      if ($urandom_range(0, 199) == 0) hz_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1499) == 0) begin
        clr = 1'b0; model_reset(); cyc(); clr = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
